// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the falling-edge spacing of a 0x55 sync character
// and drives the shared UART clks_per_bit divisor from the measured bit time.
`default_nettype none
module uart_autobaud #(
   parameter int               CPB_W       = 13,
   parameter logic [CPB_W-1:0] DEFAULT_CPB = 13'd5208,
   parameter int               MIN_CPB     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_data_bit,
   input  logic             relock,
   input  logic             ovr_en,
   input  logic [CPB_W-1:0] ovr_cpb,
   output logic [CPB_W-1:0] clks_per_bit,
   output logic             locked,
   output logic             busy,
   output logic             err
);
   localparam int CW = CPB_W + 2;
   localparam int TW = CPB_W + 3;

   typedef enum logic [1:0] {
      WAIT_START = 2'd0,
      MEASURE    = 2'd1,
      CHECK_STOP = 2'd2,
      LOCKED     = 2'd3
   } state_t;

   state_t           state_q;
   logic             sync1_q, sync2_q, prev_q;
   logic [CW-1:0]    cnt_q, i1_q;
   logic [TW-1:0]    tot_q;
   logic [2:0]       edge_q;
   logic [CPB_W-1:0] cpb_q;
   logic             locked_q, err_q;

   logic             fall, rise, tol_ok, range_ok;
   logic [CW-1:0]    ik, base, diff;
   logic [CPB_W:0]   cpb_wide;

   assign fall = prev_q & ~sync2_q;
   assign rise = ~prev_q & sync2_q;

   // ik is the interval length including the current cycle, so an ideal
   // B-cycle bit yields exactly 2B between falling edges.
   assign ik     = cnt_q + 1'b1;
   assign base   = (edge_q == 3'd1) ? ik : i1_q;
   assign diff   = (ik >= base) ? (ik - base) : (base - ik);
   assign tol_ok = diff <= (base >> 2);

   assign cpb_wide = (CPB_W+1)'(({1'b0, tot_q} + (TW+1)'(4)) >> 3);
   assign range_ok = (cpb_wide >= (CPB_W+1)'(MIN_CPB)) && !cpb_wide[CPB_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prev_q   <= 1'b1;
         state_q  <= WAIT_START;
         cnt_q    <= '0;
         i1_q     <= '0;
         tot_q    <= '0;
         edge_q   <= '0;
         cpb_q    <= DEFAULT_CPB;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync1_q <= rx_data_bit;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         err_q   <= 1'b0;
         if (relock) begin
            state_q  <= WAIT_START;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            edge_q   <= '0;
         end else begin
            case (state_q)
               WAIT_START: begin
                  cnt_q <= '0;
                  if (fall) begin
                     state_q <= MEASURE;
                     edge_q  <= 3'd1;
                     tot_q   <= '0;
                  end
               end
               MEASURE: begin
                  if (cnt_q == '1 || (fall && !tol_ok)) begin
                     err_q   <= 1'b1;
                     state_q <= WAIT_START;
                     cnt_q   <= '0;
                  end else if (fall) begin
                     if (edge_q == 3'd1) i1_q <= ik;
                     tot_q  <= tot_q + TW'(ik);
                     cnt_q  <= '0;
                     edge_q <= edge_q + 3'd1;
                     if (edge_q == 3'd4) state_q <= CHECK_STOP;
                  end else begin
                     cnt_q <= ik;
                  end
               end
               CHECK_STOP: begin
                  if (ik >= i1_q || (rise && !range_ok)) begin
                     err_q   <= 1'b1;
                     state_q <= WAIT_START;
                     cnt_q   <= '0;
                  end else if (rise) begin
                     cpb_q    <= cpb_wide[CPB_W-1:0];
                     locked_q <= 1'b1;
                     state_q  <= LOCKED;
                  end else begin
                     cnt_q <= ik;
                  end
               end
               LOCKED: begin
                  cnt_q <= '0;
               end
               default: state_q <= WAIT_START;
            endcase
         end
      end
   end

   assign clks_per_bit = ovr_en ? ovr_cpb : cpb_q;
   assign locked       = locked_q;
   assign busy         = (state_q == MEASURE) || (state_q == CHECK_STOP);
   assign err          = err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: drives sync characters with chosen bit widths and compares
// lock/divisor/error behaviour against an edge-timing model of the frame.
`default_nettype none
`timescale 1ns/1ps
module tb_uart_autobaud;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_data_bit = 1'b1;
   logic        relock = 1'b0;
   logic        ovr_en = 1'b0;
   logic [12:0] ovr_cpb = 13'd0;
   logic [12:0] clks_per_bit;
   logic        locked, busy, err;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_err = 0;
   logic [12:0] exp_cpb = 13'd5208;
   bit          f_lvl [10];
   int          f_dur [10];

   uart_autobaud #(.CPB_W(13), .DEFAULT_CPB(13'd5208), .MIN_CPB(4)) dut (
      .clk(clk), .reset(reset), .rx_data_bit(rx_data_bit), .relock(relock),
      .ovr_en(ovr_en), .ovr_cpb(ovr_cpb), .clks_per_bit(clks_per_bit),
      .locked(locked), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (err === 1'b1) n_err <= n_err + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_char(input logic [7:0] c, input int b);
      f_lvl[0] = 1'b0;
      for (int i = 0; i < 8; i++) f_lvl[1+i] = c[i];
      f_lvl[9] = 1'b1;
      for (int i = 0; i < 10; i++) f_dur[i] = b;
   endtask

   // Model: locate line edges from the segment list, then apply the
   // acquisition rules directly to edge times.
   function automatic void predict(output bit ok, output int cpb);
      int t, i1, tsum, d, ik;
      bit prev;
      int falls[$];
      int rises[$];
      t = 0; prev = 1'b1; ok = 1'b0; cpb = 0;
      for (int i = 0; i < 10; i++) begin
         if (prev && !f_lvl[i]) falls.push_back(t);
         if (!prev && f_lvl[i]) rises.push_back(t);
         t += f_dur[i];
         prev = f_lvl[i];
      end
      if (falls.size() < 5) return;
      i1 = falls[1] - falls[0];
      tsum = 0;
      for (int k = 1; k < 5; k++) begin
         ik = falls[k] - falls[k-1];
         if (((ik > i1) ? ik - i1 : i1 - ik) > i1 / 4) return;
         tsum += ik;
      end
      d = -1;
      foreach (rises[j]) if (d < 0 && rises[j] > falls[4]) d = rises[j] - falls[4];
      if (d < 0 || d >= i1) return;
      cpb = (tsum + 4) / 8;
      ok = (cpb >= 4) && (cpb < 8192);
   endfunction

   task automatic pulse_relock(input string tag);
      relock = 1'b1;
      @(posedge clk);
      #1 relock = 1'b0;
      check({tag, "/relock_locked"}, locked, 0);
      check({tag, "/relock_cpb"}, clks_per_bit, exp_cpb);
   endtask

   task automatic run_frame(input string tag, input int idle);
      bit ok;
      int cpb, e0;
      predict(ok, cpb);
      pulse_relock(tag);
      e0 = n_err;
      rx_data_bit = f_lvl[0];
      repeat (4) @(posedge clk);
      #1 check({tag, "/busy"}, busy, 1);
      repeat (f_dur[0] - 4) @(posedge clk);
      #1;
      for (int i = 1; i < 9; i++) begin
         rx_data_bit = f_lvl[i];
         repeat (f_dur[i]) @(posedge clk);
         #1;
      end
      rx_data_bit = 1'b1;
      repeat (2) @(posedge clk);
      #1 check({tag, "/pre_lock"}, locked, 0);
      @(posedge clk);
      #1 check({tag, "/lock"}, locked, ok);
      repeat (f_dur[9] - 3 + idle) @(posedge clk);
      #1;
      if (ok) exp_cpb = cpb[12:0];
      check({tag, "/cpb"}, clks_per_bit, exp_cpb);
      check({tag, "/err"}, n_err != e0, !ok);
      if (ok) check({tag, "/idle_busy"}, busy, 0);
   endtask

   initial begin
      int b, mode, k, j;
      #22;
      check("reset/cpb", clks_per_bit, 5208);
      check("reset/locked", locked, 0);
      check("reset/busy", busy, 0);
      check("reset/err", err, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      set_char(8'h00, 100);
      run_frame("wrongchar", 33000);
      check("wrongchar/cpb_default", clks_per_bit, 5208);
      check("wrongchar/busy", busy, 0);

      set_char(8'h55, 100);
      run_frame("nominal", 50);
      check("nominal/cpb100", clks_per_bit, 100);

      set_char(8'h55, 100);
      f_dur[3] = 101; f_dur[5] = 101; f_dur[7] = 101;
      run_frame("jitter803", 50);
      check("jitter803/cpb", clks_per_bit, 100);
      f_dur[1] = 101;
      run_frame("jitter804", 50);
      check("jitter804/cpb", clks_per_bit, 101);

      set_char(8'h55, 100);
      f_dur[4] = 160;
      run_frame("tolreject", 50);
      check("tolreject/cpb_held", clks_per_bit, 101);
      set_char(8'h55, 100);
      run_frame("clean", 50);
      check("clean/cpb", clks_per_bit, 100);

      set_char(8'h55, 50);
      run_frame("relock50", 50);
      check("relock50/cpb", clks_per_bit, 50);

      ovr_en = 1'b1; ovr_cpb = 13'd7;
      #1 check("ovr/cpb", clks_per_bit, 7);
      check("ovr/locked", locked, 1);
      ovr_en = 1'b0;
      #1 check("ovr/release", clks_per_bit, 50);

      // Stop partway into d3, after the third falling edge has been synchronized.
      set_char(8'h55, 100);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rx_data_bit = f_lvl[i];
         repeat (f_dur[i]) @(posedge clk);
         #1;
      end
      rx_data_bit = f_lvl[4];
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midreset/cpb", clks_per_bit, 5208);
      check("midreset/locked", locked, 0);
      check("midreset/busy", busy, 0);
      check("midreset/err", err, 0);
      exp_cpb = 13'd5208;
      rx_data_bit = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      set_char(8'h55, 80);
      run_frame("after_reset80", 50);
      check("after_reset80/cpb", clks_per_bit, 80);

      for (int n = 0; n < 12; n++) begin
         b = int'($urandom_range(8, 120));
         mode = int'($urandom_range(0, 3));
         set_char(8'h55, b);
         for (int i = 0; i < 9; i++) begin
            if (mode == 1) begin
               j = int'($urandom_range(0, 2 * (b / 8))) - b / 8;
               f_dur[i] = b + j;
            end else if (mode == 3) begin
               j = int'($urandom_range(0, 4)) - 2;
               f_dur[i] = b + j;
            end
         end
         if (mode == 2) begin
            k = int'($urandom_range(1, 8));
            f_dur[k] = b + (b * int'($urandom_range(3, 8))) / 10;
         end
         f_dur[9] = b + 5;
         run_frame($sformatf("rand%0d_b%0d_m%0d", n, b, mode), 4 * b + 40);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
